// File: rtl/pulse_gen_multi.sv
// Multi-channel edge-to-pulse generator with hold stretching and sticky overrun flags.
// Optional PULSE_GEN_SYNC_EN adds a 2-flop synchronizer on every signal_in bit.
module pulse_gen_multi #(
    parameter int CHANNELS  = 4,
    parameter int PULSE_LEN = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CHANNELS-1:0]     signal_in,
    input  logic [CHANNELS-1:0]     hold,
    input  logic [2*CHANNELS-1:0]   edge_mode,
    input  logic                    clr_overrun,
    output logic [CHANNELS-1:0]     pulse_out,
    output logic [CHANNELS-1:0]     busy,
    output logic [CHANNELS-1:0]     overrun
);
    localparam int CW = $clog2(PULSE_LEN + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_LEN);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // state    | meaning
    // ST_IDLE  | waiting for a selected edge
    // ST_PULSE | minimum-length pulse, counter running
    // ST_HOLD  | pulse stretched while hold stays high and level is unchanged
    typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_HOLD} state_t;

    state_t              state_q [CHANNELS];
    state_t              state_d [CHANNELS];
    logic [CW-1:0]       cnt_q   [CHANNELS];
    logic [CW-1:0]       cnt_d   [CHANNELS];
    logic [CHANNELS-1:0] prev_q, prev_d;
    logic [CHANNELS-1:0] hold_lat_q, hold_lat_d;
    logic [CHANNELS-1:0] lvl_q, lvl_d;
    logic [CHANNELS-1:0] pulse_q, pulse_d;
    logic [CHANNELS-1:0] ovr_q, ovr_d;
    logic [CHANNELS-1:0] sig_s;
    logic [CHANNELS-1:0] edge_det;

`ifdef PULSE_GEN_SYNC_EN
    logic [CHANNELS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

    always_comb begin
        sync1_d = signal_in;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign sig_s = sync2_q;
`else
    assign sig_s = signal_in;
`endif

    always_comb begin
        edge_det = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            case (edge_mode[2*i +: 2])
                2'b00:   edge_det[i] = sig_s[i] & ~prev_q[i];
                2'b01:   edge_det[i] = ~sig_s[i] & prev_q[i];
                2'b10:   edge_det[i] = sig_s[i] ^ prev_q[i];
                default: edge_det[i] = 1'b0;
            endcase
        end
    end

    always_comb begin
        prev_d     = sig_s;
        hold_lat_d = hold_lat_q;
        lvl_d      = lvl_q;
        ovr_d      = clr_overrun ? '0 : ovr_q;
        pulse_d    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (edge_det[i]) begin
                // A retrigger wins over expiry and over a same-cycle clear.
                state_d[i]    = ST_PULSE;
                cnt_d[i]      = CNT_LOAD;
                hold_lat_d[i] = hold[i];
                lvl_d[i]      = sig_s[i];
                if (state_q[i] != ST_IDLE) ovr_d[i] = 1'b1;
            end else begin
                case (state_q[i])
                    ST_PULSE: begin
                        hold_lat_d[i] = hold_lat_q[i] & hold[i];
                        cnt_d[i]      = cnt_q[i] - CNT_ONE;
                        if (cnt_q[i] == CNT_ONE) begin
                            if (hold_lat_q[i] && hold[i] && (sig_s[i] == lvl_q[i]))
                                state_d[i] = ST_HOLD;
                            else
                                state_d[i] = ST_IDLE;
                        end
                    end
                    ST_HOLD: begin
                        if (!(hold[i] && (sig_s[i] == lvl_q[i])))
                            state_d[i] = ST_IDLE;
                    end
                    default: state_d[i] = ST_IDLE;
                endcase
            end
            pulse_d[i] = (state_d[i] != ST_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
            prev_q     <= '0;
            hold_lat_q <= '0;
            lvl_q      <= '0;
            pulse_q    <= '0;
            ovr_q      <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            prev_q     <= prev_d;
            hold_lat_q <= hold_lat_d;
            lvl_q      <= lvl_d;
            pulse_q    <= pulse_d;
            ovr_q      <= ovr_d;
        end
    end

    assign pulse_out = pulse_q;
    assign busy      = pulse_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Bench for pulse_gen_multi: three instances (PULSE_LEN 1, 3, 4) share one stimulus,
// checked every cycle against a time-since-edge model plus literal expectations.
module tb_pulse_gen_multi;
    localparam int CH = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [CH-1:0] signal_in, hold;
    logic [2*CH-1:0] edge_mode;
    logic         clr_overrun;
    logic [CH-1:0] p1, b1, o1, p3, b3, o3, p4, b4, o4;

    pulse_gen_multi #(.CHANNELS(CH), .PULSE_LEN(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .signal_in(signal_in), .hold(hold), .edge_mode(edge_mode),
        .clr_overrun(clr_overrun), .pulse_out(p1), .busy(b1), .overrun(o1));
    pulse_gen_multi #(.CHANNELS(CH), .PULSE_LEN(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .signal_in(signal_in), .hold(hold), .edge_mode(edge_mode),
        .clr_overrun(clr_overrun), .pulse_out(p3), .busy(b3), .overrun(o3));
    pulse_gen_multi #(.CHANNELS(CH), .PULSE_LEN(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .signal_in(signal_in), .hold(hold), .edge_mode(edge_mode),
        .clr_overrun(clr_overrun), .pulse_out(p4), .busy(b4), .overrun(o4));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [CH-1:0] got, input logic [CH-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %b, expected %b", name, cyc, got, exp);
        end
    endtask

    task automatic chkb(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %b, expected %b", name, cyc, got, exp);
        end
    endtask

    // Model: output at t+1 is high if the last edge e satisfies t-e < PULSE_LEN, or hold
    // has been high on every cycle since e and the level matched on every post-minimum cycle.
    int          plen [3] = '{1, 3, 4};
    bit          act  [3][CH];
    bit          hrun [3][CH];
    bit          lrun [3][CH];
    bit          lvlm [3][CH];
    int          eat  [3][CH];
    logic [CH-1:0] ep [3];
    logic [CH-1:0] eo [3];
    logic [CH-1:0] mprev, ms1, ms2;
    logic [CH-1:0] dp [3], db [3], dov [3];

    assign dp[0] = p1; assign db[0] = b1; assign dov[0] = o1;
    assign dp[1] = p3; assign db[1] = b3; assign dov[1] = o3;
    assign dp[2] = p4; assign db[2] = b4; assign dov[2] = o4;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            ep[k] = '0;
            eo[k] = '0;
            for (int c = 0; c < CH; c++) act[k][c] = 1'b0;
        end
        mprev = '0; ms1 = '0; ms2 = '0;
    endtask

    task automatic model_step();
        logic [CH-1:0] sv;
        bit ed, bsy, nxt;
`ifdef PULSE_GEN_SYNC_EN
        sv = ms2; ms2 = ms1; ms1 = signal_in;
`else
        sv = signal_in;
`endif
        for (int c = 0; c < CH; c++) begin
            case ({edge_mode[2*c+1], edge_mode[2*c]})
                2'b00:   ed = (sv[c] == 1'b1) && (mprev[c] == 1'b0);
                2'b01:   ed = (sv[c] == 1'b0) && (mprev[c] == 1'b1);
                2'b10:   ed = (sv[c] != mprev[c]);
                default: ed = 1'b0;
            endcase
            for (int k = 0; k < 3; k++) begin
                bsy = ep[k][c];
                if (ed && bsy) eo[k][c] = 1'b1;
                else if (clr_overrun) eo[k][c] = 1'b0;
                if (ed) begin
                    act[k][c] = 1'b1; eat[k][c] = cyc;
                    hrun[k][c] = hold[c]; lvlm[k][c] = sv[c]; lrun[k][c] = 1'b1;
                end else if (act[k][c]) begin
                    hrun[k][c] = hrun[k][c] && hold[c];
                    if (cyc - eat[k][c] >= plen[k]) lrun[k][c] = lrun[k][c] && (sv[c] == lvlm[k][c]);
                end
                nxt = act[k][c] && ((cyc - eat[k][c] < plen[k]) || (hrun[k][c] && lrun[k][c]));
                act[k][c] = nxt;
                ep[k][c]  = nxt;
            end
            mprev[c] = sv[c];
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) model_reset();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("d%0d.pulse_out", plen[k]), dp[k], ep[k]);
            chk($sformatf("d%0d.busy", plen[k]), db[k], ep[k]);
            chk($sformatf("d%0d.overrun", plen[k]), dov[k], eo[k]);
        end
        if (rst_n) model_step();
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic look(input int c);
        goto(c);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; signal_in = '0; hold = '0; edge_mode = '0; clr_overrun = 1'b0;
        goto(2); rst_n = 1'b1;
`ifdef PULSE_GEN_SYNC_EN
        goto(10); signal_in[0] = 1'b1;
        look(12); chkb("sync d1 p0 early", p1[0], 1'b0);
        look(13); chkb("sync d1 p0 rise", p1[0], 1'b1);
        look(14); chkb("sync d1 p0 end", p1[0], 1'b0);
        look(16); chkb("sync d3 p0 last", p3[0], 1'b0);
        goto(30);
`else
        goto(10); signal_in[0] = 1'b1;
        look(10); chkb("d1 p0 pre", p1[0], 1'b0);
        look(11); chkb("d1 p0 pulse", p1[0], 1'b1); chkb("d1 ov0 single", o1[0], 1'b0);
        look(12); chkb("d1 p0 end", p1[0], 1'b0);
        look(13); chkb("d3 p0 last", p3[0], 1'b1);
        look(14); chkb("d3 p0 end", p3[0], 1'b0);
        goto(15); edge_mode[3:2] = 2'b01; signal_in[1] = 1'b1;
        look(16); chkb("d3 p1 rise ignored", p3[1], 1'b0);
        goto(20); signal_in[1] = 1'b0;
        look(21); chkb("d3 p1 first", p3[1], 1'b1);
        look(23); chkb("d3 p1 last", p3[1], 1'b1);
        look(24); chkb("d3 p1 end", p3[1], 1'b0);
        goto(25); edge_mode[7:6] = 2'b10;
        goto(30); signal_in[3] = 1'b1;
        goto(32); signal_in[3] = 1'b0;
        look(32); chkb("d4 ov3 before", o4[3], 1'b0);
        look(33); chkb("d4 ov3 set", o4[3], 1'b1); chkb("d1 ov3 no overlap", o1[3], 1'b0);
        look(36); chkb("d4 p3 last", p4[3], 1'b1);
        look(37); chkb("d4 p3 end", p4[3], 1'b0);
        goto(38); signal_in[3] = 1'b1;
        goto(40); signal_in[3] = 1'b0; clr_overrun = 1'b1; signal_in[2] = 1'b1; hold[2] = 1'b1;
        goto(41); clr_overrun = 1'b0;
        look(41); chkb("d4 ov3 set beats clr", o4[3], 1'b1); chkb("d1 p2 start", p1[2], 1'b1);
        goto(45); clr_overrun = 1'b1;
        goto(46); clr_overrun = 1'b0;
        look(46); chkb("d4 ov3 cleared", o4[3], 1'b0);
        goto(47); hold[2] = 1'b0;
        look(47); chkb("d1 p2 held", p1[2], 1'b1);
        look(48); chkb("d1 p2 hold drop", p1[2], 1'b0); chkb("d4 p2 hold drop", p4[2], 1'b0);
        goto(50); signal_in[2] = 1'b0;
        goto(55); signal_in[2] = 1'b1; hold[2] = 1'b1;
        goto(59); signal_in[2] = 1'b0;
        look(59); chkb("d1 p2 held2", p1[2], 1'b1);
        look(60); chkb("d1 p2 level drop", p1[2], 1'b0); chkb("d3 p2 level drop", p3[2], 1'b0);
        goto(61); hold[2] = 1'b0;
        goto(70); edge_mode[1:0] = 2'b10;
        goto(72); signal_in[0] = 1'b0;
        goto(73); signal_in[0] = 1'b1;
        look(73); chkb("d1 p0 b2b a", p1[0], 1'b1); chkb("d1 ov0 first edge", o1[0], 1'b0);
        goto(74); signal_in[0] = 1'b0;
        look(74); chkb("d1 p0 b2b b", p1[0], 1'b1); chkb("d1 ov0 second edge", o1[0], 1'b1);
        goto(75); signal_in[0] = 1'b1;
        look(75); chkb("d1 p0 b2b c", p1[0], 1'b1);
        look(76); chkb("d1 p0 b2b d", p1[0], 1'b1);
        look(77); chkb("d1 p0 b2b end", p1[0], 1'b0);
        goto(80); edge_mode[3:2] = 2'b00; signal_in[1] = 1'b1;
        goto(81); edge_mode[3:2] = 2'b11;
        look(84); chkb("d4 p1 completes", p4[1], 1'b1);
        look(85); chkb("d4 p1 end", p4[1], 1'b0);
        goto(86); signal_in[1] = 1'b0;
        look(87); chkb("d4 p1 disabled", p4[1], 1'b0); chkb("d1 p1 disabled", p1[1], 1'b0);
        goto(90); signal_in[2] = 1'b1; hold[2] = 1'b1;
        look(93); chkb("d1 p2 held pre-reset", p1[2], 1'b1);
        goto(95); #2; rst_n = 1'b0; #1;
        chk("async rst d1 pulse_out", p1, '0); chk("async rst d1 busy", b1, '0);
        chk("async rst d1 overrun", o1, '0); chk("async rst d4 pulse_out", p4, '0);
        goto(98); rst_n = 1'b1;
        look(98); chkb("d1 p2 at release", p1[2], 1'b0);
        look(99); chkb("d1 p2 after release", p1[2], 1'b1);
        goto(100); hold[2] = 1'b0;
        look(101); chkb("d1 p2 released hold", p1[2], 1'b0);
        goto(110);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pulse_gen_multi.md
# pulse_gen_multi

Multi-channel, parametrised edge-to-pulse generator with registered outputs. Each channel turns a selected edge (rising, falling or both) on a level input into a pulse of at least `PULSE_LEN` cycles. A per-channel hold input stretches that pulse for as long as the requester keeps holding it. It sits between level-style status signals (FIFO ready/empty, done flags) and request/strobe consumers. It also flags edges that arrive while a pulse is still active.

## Interface
- `CHANNELS`, default 4: number of independent channels, ≥1.
- `PULSE_LEN`, default 1: minimum pulse length in cycles, ≥1. Counter width is `$clog2(PULSE_LEN+1)`.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low. One clock, `clk`. Reset is asynchronous and active-low.
- `signal_in`  in  CHANNELS  level inputs. Synchronous to `clk` unless `PULSE_GEN_SYNC_EN` is defined.
- `hold`  in  CHANNELS  per-channel pulse-hold request. Always synchronous to `clk`.
- `edge_mode`  in  2*CHANNELS  per-channel mode in bits [2i+1:2i]: 00 rising, 01 falling, 10 both, 11 disabled.
- `clr_overrun`  in  1  single-cycle clear of all overrun flags.
- `pulse_out`  out  CHANNELS  registered pulses.
- `busy`  out  CHANNELS  channel is in PULSE or HOLD (registered).
- `overrun`  out  CHANNELS  sticky: an edge was detected while the channel was busy.

## Operation
- Per channel: `prev` register holds last sampled `signal_in`. An edge is detected in cycle N when `signal_in != prev` and the direction matches `edge_mode`. Mode 11 never detects.
- State machine per channel:
  - IDLE → PULSE on edge. Load counter with `PULSE_LEN`. Set `hold_lat = hold[i]`. Capture `lvl = signal_in[i]` (the post-edge level).
  - PULSE: the counter decrements each cycle. When it reaches 0:
    - go to HOLD if `hold_lat && hold[i] && signal_in[i]==lvl`;
    - otherwise go to IDLE.
  - HOLD: stay while `hold[i] && signal_in[i]==lvl`. Otherwise go to IDLE.
  - `hold_lat` clears when `hold[i]` drops during PULSE. The minimum length `PULSE_LEN` is still honoured.
- Retrigger: an edge detected in PULSE or HOLD does all of the following:
  - reloads the counter;
  - recaptures `lvl` and `hold_lat`;
  - enters or stays in PULSE;
  - sets `overrun[i]`.
- `overrun`: set has priority over a simultaneous `clr_overrun`.
- `edge_mode` changes apply only to edges detected after the change. A pulse already in progress completes normally.
- `pulse_out[i]` and `busy[i]` are both registered versions of "state != IDLE" and are identical.

## Timing
- Reset values: all outputs 0, `prev` 0, every state IDLE, counters 0.
  - Consequence: a high input at reset release is a rising edge in the first cycle.
- Latency: edge sampled at cycle N → `pulse_out` high from N+1.
- Without hold, the pulse is exactly `PULSE_LEN` cycles, N+1 … N+PULSE_LEN.
- Held pulse: falls in the cycle after the first sample where `hold[i]==0` or `signal_in[i]!=lvl`, measured once the counter has expired.
- Back-to-back edges every cycle keep `pulse_out` high continuously. `overrun` sets on the second edge.
- Asynchronous reset mid-pulse: all outputs drop immediately, with no pending pulse.

## Configuration
- `PULSE_GEN_SYNC_EN` defined:
  - each `signal_in` bit passes through a 2-flop synchronizer (reset 0) before edge detection;
  - edge-to-pulse latency becomes 3 cycles;
  - the `hold` comparison against `lvl` uses the synchronised value.
- Undefined: `signal_in` feeds edge detection directly, with 1-cycle latency.

## Test plan
- CHANNELS=4, PULSE_LEN=1, all modes rising. `signal_in[0]` goes 0→1 at cycle 10 and stays high → `pulse_out[0]` high only at cycle 11; `overrun`=0.
- PULSE_LEN=3, falling mode on ch1, `signal_in[1]` goes 1→0 at cycle 20 → `pulse_out[1]` high for cycles 21–23; a rising edge on ch1 produces nothing.
- ch2 rising with `hold[2]`=1 at the edge (cycle 5), `hold` drops at cycle 12 → `pulse_out[2]` high for cycles 6–12, low at 13. Repeat with `signal_in` dropping at cycle 9 instead → low at 10.
- ch3 both-edge mode, PULSE_LEN=4, edges at cycles 30 and 32 → `pulse_out[3]` high for cycles 31–36; `overrun[3]` set at 33. `clr_overrun` and a new retrigger in the same cycle → `overrun` stays 1.
- `rst_n` asserted asynchronously mid-held-pulse → `pulse_out`/`busy`/`overrun` go 0 immediately. Input held high through reset release → pulse one cycle after release.
- With `PULSE_GEN_SYNC_EN` defined, a rising edge at cycle 10 → `pulse_out` high at cycle 13.
